// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
//   Shared types and helpers for spi_frame_arbiter and its sub-modules.
//   - state_t   : frame sequencer states
//   - byte_sel  : picks byte idx of a frame, byte 0 being the MSB byte
//   - BYTE_W / MAX_BPF / MAX_FW / BYTE_IDX_W : width constants
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_BPF    = 4;
    localparam int MAX_FW     = MAX_BPF * BYTE_W;
    localparam int BYTE_IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT,
        FINISH
    } state_t;

    // Frames go out MSB byte first, so byte 0 sits at the top of the
    // bpf-byte frame (the frame is zero-extended to MAX_FW).
    function automatic logic [BYTE_W-1:0] byte_sel(
        input logic [MAX_FW-1:0]     frame,
        input int                    bpf,
        input logic [BYTE_IDX_W-1:0] idx
    );
        int pos;
        pos = (bpf - 1 - int'(idx)) * BYTE_W;
        return frame[pos +: BYTE_W];
    endfunction

endpackage

// File: rtl/spi_frame_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: returns the first asserted request at or
//   after ptr, wrapping past NUM_REQ-1 back to 0. The pointer register
//   itself is owned by the parent.
// Ports:
//   req         in   NUM_REQ  request vector
//   ptr         in   IDW      index with highest priority this cycle
//   grant_idx   out  IDW      winning index (0 when no request)
//   grant_valid out  1        at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        int j;
        j           = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        // Scan from the farthest offset down to offset 0: the last hit
        // written is the closest one to ptr, which is the winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                grant_idx   = IDW'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_arbiter.sv
// ---------------------------------------------------------------------------
// spi_frame_arbiter
//   Shares one byte-level spi_master between NUM_REQ requesters. A round-robin
//   grant owns a whole BYTES_PER_FRAME-byte frame: its slave select is held
//   low for the full frame, bytes go out MSB byte first, and the received
//   frame is returned with a one-cycle ack / rx_valid.
//   Optional feature macro: SPI_TIMEOUT_EN (abort a byte after
//   TIMEOUT_CYCLES without spi_done; err_timeout is tied 0 otherwise).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req / req_data          per-requester level request and frame
//   ack                     one-cycle pulse to the granted requester at frame end
//   rx_frame/rx_valid/rx_id received frame, its strobe, and its owner
//   busy                    high outside IDLE
//   err_timeout             one-cycle pulse on an aborted frame
//   spi_start/spi_tx_data   byte request to spi_master
//   spi_rx_data/spi_done    byte result from spi_master
//   ss_n                    per-requester active-low slave select
// ---------------------------------------------------------------------------
module spi_frame_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int BYTES_PER_FRAME = 2,
    parameter int SS_SETUP_CYCLES = 1,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*8*BYTES_PER_FRAME-1:0]  req_data,
    output logic [NUM_REQ-1:0]                    ack,
    output logic [8*BYTES_PER_FRAME-1:0]          rx_frame,
    output logic                                  rx_valid,
    output logic [$clog2(NUM_REQ)-1:0]            rx_id,
    output logic                                  busy,
    output logic                                  err_timeout,
    output logic                                  spi_start,
    output logic [7:0]                            spi_tx_data,
    input  logic [7:0]                            spi_rx_data,
    input  logic                                  spi_done,
    output logic [NUM_REQ-1:0]                    ss_n
);

    localparam int FW      = BYTE_W * BYTES_PER_FRAME;
    localparam int IDW     = $clog2(NUM_REQ);
    localparam int SETUP_W = $clog2(SS_SETUP_CYCLES + 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_FRAME - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BYTES_PER_FRAME < 1 || BYTES_PER_FRAME > 4 ||
        SS_SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_frame_arbiter: parameter out of range");
    end

    state_t                state;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        grant_q;
    logic [FW-1:0]         frame_q;
    logic [FW-1:0]         shift_q;
    logic [FW-1:0]         shift_next;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [BYTE_IDX_W-1:0] next_idx;
    logic [SETUP_W-1:0]    setup_cnt;
    logic [IDW-1:0]        grant_idx;
    logic                  grant_valid;

`ifdef SPI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req         (req),
        .ptr         (ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Received bytes enter at the bottom, so the first byte ends in the MSBs.
    assign shift_next = (shift_q << BYTE_W) | FW'(spi_rx_data);
    assign next_idx   = byte_idx + BYTE_IDX_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_q     <= '0;
            frame_q     <= '0;
            shift_q     <= '0;
            byte_idx    <= '0;
            setup_cnt   <= '0;
            ss_n        <= '1;
            spi_start   <= 1'b0;
            spi_tx_data <= '0;
            ack         <= '0;
            rx_frame    <= '0;
            rx_valid    <= 1'b0;
            rx_id       <= '0;
            busy        <= 1'b0;
`ifdef SPI_TIMEOUT_EN
            to_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the states below raise them for one cycle.
            spi_start <= 1'b0;
            ack       <= '0;
            rx_valid  <= 1'b0;
`ifdef SPI_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_q         <= grant_idx;
                        ptr             <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0
                                                                            : grant_idx + IDW'(1);
                        frame_q         <= req_data[int'(grant_idx)*FW +: FW];
                        ss_n[grant_idx] <= 1'b0;  // ss_n is all-ones in IDLE
                        byte_idx        <= '0;
                        setup_cnt       <= '0;
                        shift_q         <= '0;
                        busy            <= 1'b1;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SETUP_W'(SS_SETUP_CYCLES - 1)) begin
                        spi_start   <= 1'b1;
                        spi_tx_data <= byte_sel(MAX_FW'(frame_q), BYTES_PER_FRAME, byte_idx);
                        state       <= SEND;
                    end else begin
                        setup_cnt <= setup_cnt + SETUP_W'(1);
                    end
                end
                SEND: begin
`ifdef SPI_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        shift_q  <= shift_next;
                        byte_idx <= next_idx;
                        if (byte_idx == LAST_IDX) begin
                            ss_n          <= '1;
                            ack[grant_q]  <= 1'b1;
                            rx_valid      <= 1'b1;
                            rx_frame      <= shift_next;
                            rx_id         <= grant_q;
                            state         <= FINISH;
                        end else begin
                            // SS stays low between bytes of one frame.
                            spi_start   <= 1'b1;
                            spi_tx_data <= byte_sel(MAX_FW'(frame_q), BYTES_PER_FRAME, next_idx);
                            state       <= SEND;
                        end
                    end
`ifdef SPI_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: requester is released, rx_frame keeps its old value.
                        ss_n         <= '1;
                        ack[grant_q] <= 1'b1;
                        err_timeout  <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                FINISH: begin
                    // SS is already high here, and IDLE adds another high
                    // cycle, so each frame starts on a fresh SS edge.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_arbiter
//   Self-checking bench for spi_frame_arbiter (3 requesters, 2-byte frames,
//   3 setup cycles, 16-cycle timeout when SPI_TIMEOUT_EN is defined).
//   Expected grants come from a round-robin model over the request vector;
//   expected bytes and frames come from the bench's own data arrays.
// ---------------------------------------------------------------------------
module tb_spi_frame_arbiter;

    localparam int NR    = 3;
    localparam int BPF   = 2;
    localparam int FW    = 8 * BPF;
    localparam int SETUP = 3;
    localparam int TO    = 16;
    localparam int IDW   = $clog2(NR);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*FW-1:0]  req_data = '0;
    logic [NR-1:0]     ack;
    logic [FW-1:0]     rx_frame;
    logic              rx_valid;
    logic [IDW-1:0]    rx_id;
    logic              busy;
    logic              err_timeout;
    logic              spi_start;
    logic [7:0]        spi_tx_data;
    logic [7:0]        spi_rx_data = '0;
    logic              spi_done = 1'b0;
    logic [NR-1:0]     ss_n;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int            ptr_m = 0;
    logic [NR-1:0] req_vec = '0;
    logic [FW-1:0] data_m [NR];
    logic [FW-1:0] rx_model = '0;

    always #5 clk = ~clk;

    spi_frame_arbiter #(
        .NUM_REQ         (NR),
        .BYTES_PER_FRAME (BPF),
        .SS_SETUP_CYCLES (SETUP),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .rx_frame    (rx_frame),
        .rx_valid    (rx_valid),
        .rx_id       (rx_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_rx_data (spi_rx_data),
        .spi_done    (spi_done),
        .ss_n        (ss_n)
    );

    task automatic apply();
        req = req_vec;
        for (int i = 0; i < NR; i++) req_data[i*FW +: FW] = data_m[i];
    endtask

    // Round robin: first pending index at or after p, wrapping.
    function automatic int rr_model(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++)
            if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    // Runs one frame for the model's next grant; the caller has set req_vec
    // at a negedge while the DUT is idle. Ends on the idle negedge after ack.
    task automatic do_frame(input logic [FW-1:0] rx_word, input bit mid_change, input bit spurious);
        int            g;
        int            n;
        logic [FW-1:0] exp_tx;
        logic [NR-1:0] exp_ss;
        logic [7:0]    exp_byte;
        g = rr_model(req_vec, ptr_m);
        n_cmp++;
        if (g < 0) begin
            n_err++;
            $display("FAIL frame_setup: req_vec=%b has no pending request", req_vec);
            return;
        end
        ptr_m  = (g + 1) % NR;
        exp_tx = data_m[g];
        exp_ss = ~(NR'(1) << g);
        @(negedge clk);
        n_cmp++;
        if (ss_n !== exp_ss) begin
            n_err++; $display("FAIL grant_ss: ss_n=%b want %b", ss_n, exp_ss);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL busy_frame: busy=%b want 1", busy);
        end
        if (spurious) begin
            spi_done    = 1'b1;  // arrives in SETUP and must be ignored
            spi_rx_data = 8'hEE;
        end
        for (int b = 0; b < BPF; b++) begin
            n = 0;
            while (spi_start !== 1'b1 && n < 40) begin
                @(negedge clk);
                spi_done = 1'b0;
                n++;
            end
            n_cmp++;
            if (n >= 40) begin
                n_err++; $display("FAIL start_wait: no spi_start for byte %0d within 40 cycles", b);
                return;
            end
            if (b == 0) begin
                n_cmp++;
                if (n !== SETUP) begin
                    n_err++; $display("FAIL setup_delay: start %0d cycles after ss fall, want %0d", n, SETUP);
                end
            end
            exp_byte = exp_tx[(BPF-1-b)*8 +: 8];
            n_cmp++;
            if (spi_tx_data !== exp_byte) begin
                n_err++; $display("FAIL tx_byte%0d: got %h want %h", b, spi_tx_data, exp_byte);
            end
            n_cmp++;
            if (ss_n !== exp_ss) begin
                n_err++; $display("FAIL ss_hold: ss_n=%b want %b", ss_n, exp_ss);
            end
            n = $urandom_range(1, 3);
            for (int w = 0; w < n; w++) begin
                @(negedge clk);
                n_cmp++;
                if (spi_start !== 1'b0 || spi_tx_data !== exp_byte || ss_n !== exp_ss) begin
                    n_err++;
                    $display("FAIL wait_stable: start=%b tx=%h ss_n=%b want start=0 tx=%h ss_n=%b",
                             spi_start, spi_tx_data, ss_n, exp_byte, exp_ss);
                end
            end
            spi_done    = 1'b1;
            spi_rx_data = rx_word[(BPF-1-b)*8 +: 8];
            @(negedge clk);
            spi_done    = 1'b0;
            spi_rx_data = 8'($urandom);
            if (mid_change && b == 0) begin
                req_vec[g] = 1'b0;
                data_m[g]  = ~data_m[g];
                apply();
            end
        end
        n_cmp++;
        if (ack !== (NR'(1) << g)) begin
            n_err++; $display("FAIL ack: got %b want %b", ack, NR'(1) << g);
        end
        n_cmp++;
        if (rx_valid !== 1'b1) begin
            n_err++; $display("FAIL rx_valid: got %b want 1", rx_valid);
        end
        n_cmp++;
        if (rx_frame !== rx_word) begin
            n_err++; $display("FAIL rx_frame: got %h want %h", rx_frame, rx_word);
        end
        n_cmp++;
        if (rx_id !== IDW'(g)) begin
            n_err++; $display("FAIL rx_id: got %0d want %0d", rx_id, g);
        end
        n_cmp++;
        if (ss_n !== '1 || err_timeout !== 1'b0) begin
            n_err++; $display("FAIL finish_ss: ss_n=%b err=%b want all ones, err 0", ss_n, err_timeout);
        end
        rx_model   = rx_word;
        req_vec[g] = 1'b0;
        apply();
        @(negedge clk);
        n_cmp++;
        if (ss_n !== '1 || ack !== '0 || rx_valid !== 1'b0) begin
            n_err++; $display("FAIL gap: ss_n=%b ack=%b rx_valid=%b want all ones, 0, 0", ss_n, ack, rx_valid);
        end
    endtask

    // Waits for the first spi_start of a frame already requested; returns 0 on timeout.
    task automatic start_frame(output bit ok, output logic [NR-1:0] exp_ss);
        int g;
        int n;
        g      = rr_model(req_vec, ptr_m);
        ptr_m  = (g + 1) % NR;
        exp_ss = ~(NR'(1) << g);
        n = 0;
        @(negedge clk);
        while (spi_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 40);
        n_cmp++;
        if (!ok || ss_n !== exp_ss) begin
            n_err++; $display("FAIL frame_start: started=%0d ss_n=%b want 1, %b", ok, ss_n, exp_ss);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ss_n, spi_start, spi_tx_data, ack, rx_frame, rx_valid, rx_id, busy, err_timeout}
            !== {{NR{1'b1}}, 1'b0, 8'h00, {NR{1'b0}}, {FW{1'b0}}, 1'b0, {IDW{1'b0}}, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: ss_n=%b start=%b tx=%h ack=%b rx=%h rv=%b id=%0d busy=%b err=%b",
                     ss_n, spi_start, spi_tx_data, ack, rx_frame, rx_valid, rx_id, busy, err_timeout);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ss_n !== '1 || busy !== 1'b0 || spi_start !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: ss_n=%b busy=%b start=%b", ss_n, busy, spi_start);
        end
    endtask

    task automatic test_single();
        data_m[0] = 16'h12AB;
        req_vec   = 3'b001;
        apply();
        do_frame(16'h5AC3, 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        for (int f = 0; f < 4; f++) begin
            req_vec[1:0] = 2'b11;
            for (int i = 0; i < 2; i++) data_m[i] = FW'($urandom);
            apply();
            do_frame(FW'($urandom), 1'b0, 1'b0);
        end
        req_vec = '0;
        apply();
    endtask

    task automatic test_mid_frame();
        req_vec   = 3'b010;
        data_m[1] = FW'($urandom);
        apply();
        do_frame(FW'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_vec[i] && ($urandom % 2) == 1) begin
                    req_vec[i] = 1'b1;
                    data_m[i]  = FW'($urandom);
                end
            end
            if (req_vec == '0) begin
                req_vec[$urandom % NR] = 1'b1;
            end
            apply();
            do_frame(FW'($urandom), 1'b0, (it % 4) == 0);
        end
        while (req_vec != '0) do_frame(FW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_reset_wait();
        bit            ok;
        int            bad;
        logic [NR-1:0] exp_ss;
        req_vec   = 3'b001;
        data_m[0] = FW'($urandom);
        apply();
        start_frame(ok, exp_ss);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        req_vec = '0;
        apply();
        @(negedge clk);
        n_cmp++;
        if (ss_n !== '1 || busy !== 1'b0 || spi_start !== 1'b0 || rx_frame !== '0) begin
            n_err++;
            $display("FAIL reset_in_wait: ss_n=%b busy=%b start=%b rx=%h", ss_n, busy, spi_start, rx_frame);
        end
        reset    = 1'b0;
        ptr_m    = 0;
        rx_model = '0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (spi_start !== 1'b0 || ss_n !== '1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL quiet_after_reset: %0d active cycles, want 0", bad);
        end
        req_vec   = 3'b101;
        data_m[0] = FW'($urandom);
        data_m[2] = FW'($urandom);
        apply();
        do_frame(FW'($urandom), 1'b0, 1'b0);
        do_frame(FW'($urandom), 1'b0, 1'b0);
    endtask

`ifdef SPI_TIMEOUT_EN
    task automatic test_timeout();
        bit            ok;
        int            n;
        logic [NR-1:0] exp_ss;
        req_vec   = 3'b010;
        data_m[1] = FW'($urandom);
        apply();
        start_frame(ok, exp_ss);
        n = 0;
        @(negedge clk);
        while (ack === '0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n !== TO) begin
            n_err++; $display("FAIL timeout_cycles: abort after %0d wait cycles, want %0d", n, TO);
        end
        n_cmp++;
        if (err_timeout !== 1'b1 || ack !== ~exp_ss || rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse: err=%b ack=%b rv=%b want 1, %b, 0", err_timeout, ack, rx_valid, ~exp_ss);
        end
        n_cmp++;
        if (rx_frame !== rx_model || ss_n !== '1) begin
            n_err++; $display("FAIL timeout_state: rx=%h ss_n=%b want %h, all ones", rx_frame, ss_n, rx_model);
        end
        req_vec = '0;
        apply();
        @(negedge clk);
        n_cmp++;
        if (err_timeout !== 1'b0 || ack !== '0) begin
            n_err++; $display("FAIL timeout_one_cycle: err=%b ack=%b want 0", err_timeout, ack);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit            ok;
        int            bad;
        logic [NR-1:0] exp_ss;
        req_vec   = 3'b010;
        data_m[1] = FW'($urandom);
        apply();
        start_frame(ok, exp_ss);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ack !== '0 || busy !== 1'b1 || ss_n !== exp_ss || err_timeout !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL wait_forever: %0d cycles left WAIT, want 0", bad);
        end
        reset   = 1'b1;
        req_vec = '0;
        apply();
        @(negedge clk);
        reset    = 1'b0;
        ptr_m    = 0;
        rx_model = '0;
        @(negedge clk);
        n_cmp++;
        if (ss_n !== '1 || busy !== 1'b0) begin
            n_err++; $display("FAIL recover_reset: ss_n=%b busy=%b", ss_n, busy);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NR; i++) data_m[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_mid_frame();
        test_random();
        test_reset_wait();
`ifdef SPI_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        req_vec   = 3'b001;
        data_m[0] = FW'($urandom);
        apply();
        do_frame(FW'($urandom), 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
